// File: rtl/risc16_datapath.sv
// risc16_datapath: register file, Rp/Rq operand latches, registered 8-op ALU and write-back mux
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   RF_W_data, RF_s1/s0   8-bit immediate and write-back select {s1,s0}
//   RF_W_addr/RF_W_wr     write port
//   RF_Rp_*/RF_Rq_*       read ports into the Rp/Rq latches (1 clk latency, no bypass)
//   alu_s, R_data         ALU op select, data memory read data
//   RF_Rp_zero, W_data    Rp latch == 0, store data (= Rp latch)
//   alu_q/carry_q/ovf_q   registered ALU result and flags
//   sel_err               sticky flag for a write attempted with select 2'b11
module risc16_datapath #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    RF_W_data,
  input  logic          RF_s1,
  input  logic          RF_s0,
  input  logic [AW-1:0] RF_W_addr,
  input  logic          RF_W_wr,
  input  logic [AW-1:0] RF_Rp_addr,
  input  logic          RF_Rp_rd,
  input  logic [AW-1:0] RF_Rq_addr,
  input  logic          RF_Rq_rd,
  input  logic [2:0]    alu_s,
  input  logic [W-1:0]  R_data,
  output logic          RF_Rp_zero,
  output logic [W-1:0]  W_data,
  output logic [W-1:0]  alu_q,
  output logic          carry_q,
  output logic          ovf_q,
  output logic          sel_err
);
  logic [W-1:0] rf [2**AW];
  logic [W-1:0] rp_q, rq_q, alu_r, wb_data;
  logic         alu_c, alu_v;
  logic [W:0]   sum, dif;
  logic [1:0]   wb_sel;
  assign wb_sel     = {RF_s1, RF_s0};
  assign sum        = {1'b0, rp_q} + {1'b0, rq_q};
  assign dif        = {1'b0, rp_q} - {1'b0, rq_q};
  assign RF_Rp_zero = rp_q == '0;
  assign W_data     = rp_q;
  assign wb_data    = wb_sel == 2'b00 ? alu_q :
                      wb_sel == 2'b01 ? R_data : {{(W-8){RF_W_data[7]}}, RF_W_data};
  // dif[W] is the borrow of the unsigned subtraction
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_s)
      3'b000: begin
        {alu_c, alu_r} = sum;
        alu_v = (rp_q[W-1] == rq_q[W-1]) && (sum[W-1] != rp_q[W-1]);
      end
      3'b001: begin
        {alu_c, alu_r} = dif;
        alu_v = (rp_q[W-1] != rq_q[W-1]) && (dif[W-1] != rp_q[W-1]);
      end
      3'b010: alu_r = rp_q & rq_q;
      3'b011: alu_r = rp_q | rq_q;
      3'b100: alu_r = rp_q ^ rq_q;
      3'b101: alu_r = ~rp_q;
      3'b110: {alu_c, alu_r} = {rp_q, 1'b0};
      default: {alu_r, alu_c} = {1'b0, rp_q};
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) rf[i] <= '0;
      rp_q    <= '0;
      rq_q    <= '0;
      alu_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      if (RF_Rp_rd) rp_q <= rf[RF_Rp_addr];
      if (RF_Rq_rd) rq_q <= rf[RF_Rq_addr];
      alu_q   <= alu_r;
      carry_q <= alu_c;
      ovf_q   <= alu_v;
      if (RF_W_wr && wb_sel == 2'b11) sel_err <= 1'b1;
      else if (RF_W_wr) rf[RF_W_addr] <= wb_data;
    end
endmodule

// File: tb/tb_risc16_datapath.sv
// tb_risc16_datapath: randomized and directed checks of risc16_datapath against an integer reference model
module tb_risc16_datapath;
  logic        clk = 0, reset = 0;
  logic [7:0]  imm = 0;
  logic [1:0]  sel = 0;
  logic [3:0]  w_addr = 0, p_addr = 0, q_addr = 0;
  logic        w_wr = 0, p_rd = 0, q_rd = 0;
  logic [2:0]  alu_s = 0;
  logic [15:0] r_data = 0;
  logic        rp_zero, carry_q, ovf_q, sel_err;
  logic [15:0] w_data, alu_q;
  int checks = 0, errors = 0;
  int m_rf [16];
  int m_rp, m_rq, m_alu;
  bit m_c, m_v, m_err;

  risc16_datapath dut (
    .clk(clk), .reset(reset), .RF_W_data(imm), .RF_s1(sel[1]), .RF_s0(sel[0]),
    .RF_W_addr(w_addr), .RF_W_wr(w_wr), .RF_Rp_addr(p_addr), .RF_Rp_rd(p_rd),
    .RF_Rq_addr(q_addr), .RF_Rq_rd(q_rd), .alu_s(alu_s), .R_data(r_data),
    .RF_Rp_zero(rp_zero), .W_data(w_data), .alu_q(alu_q), .carry_q(carry_q),
    .ovf_q(ovf_q), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int r, output bit c, output bit v);
    int sa, sb;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin r = (a + b) % 65536; c = a + b > 65535; v = sa + sb > 32767 || sa + sb < -32768; end
      1: begin r = (a - b + 65536) % 65536; c = a < b; v = sa - sb > 32767 || sa - sb < -32768; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin r = (a * 2) % 65536; c = a > 32767; end
      default: begin r = a / 2; c = (a % 2) == 1; end
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_rp = 0; m_rq = 0; m_alu = 0; m_c = 0; m_v = 0; m_err = 0;
  endtask

  task automatic idle();
    w_wr = 0; p_rd = 0; q_rd = 0;
  endtask

  task automatic clock();
    int na, np, nq, wb;
    bit nc, nv;
    alu_ref(int'(alu_s), m_rp, m_rq, na, nc, nv);
    np = p_rd ? m_rf[p_addr] : m_rp;
    nq = q_rd ? m_rf[q_addr] : m_rq;
    wb = sel == 0 ? m_alu : sel == 1 ? int'(r_data) : (imm >= 128 ? int'(imm) + 65280 : int'(imm));
    if (w_wr && sel == 3) m_err = 1;
    else if (w_wr) m_rf[w_addr] = wb;
    m_rp = np; m_rq = nq; m_alu = na; m_c = nc; m_v = nv;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] s, input logic [7:0] i, input logic [15:0] d);
    w_addr = a; sel = s; imm = i; r_data = d; w_wr = 1;
    clock();
    idle();
  endtask

  task automatic rd(input logic [3:0] p, input logic [3:0] q);
    p_addr = p; q_addr = q; p_rd = 1; q_rd = 1;
    clock();
    idle();
  endtask

  task automatic test_reset();
    reset = 1; #1;
    checks++; if (rp_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", rp_zero); end
    checks++; if ({alu_q, w_data, carry_q, ovf_q, sel_err} !== 35'd0) begin errors++;
      $display("FAIL reset_regs alu_q=%h w_data=%h c=%b v=%b err=%b want all 0", alu_q, w_data, carry_q, ovf_q, sel_err); end
    @(posedge clk); #1; reset = 0;
    model_reset();
    alu_s = 3'b000;
    rd(3, 7);
    checks++; if (w_data !== 16'h0 || rp_zero !== 1'b1 || sel_err !== 1'b0) begin errors++;
      $display("FAIL reset_read w_data=%h zero=%b err=%b want 0000 1 0", w_data, rp_zero, sel_err); end
    clock();
    checks++; if (alu_q !== 16'h0) begin errors++; $display("FAIL reset_alu got %h want 0000", alu_q); end
  endtask

  task automatic test_imm();
    wr(2, 2'b10, 8'hF6, 16'h0);
    rd(2, 0);
    checks++; if (w_data !== 16'hFFF6) begin errors++; $display("FAIL imm_neg got %h want fff6", w_data); end
    wr(2, 2'b10, 8'h7F, 16'h0);
    rd(2, 0);
    checks++; if (w_data !== 16'h007F || rp_zero !== 1'b0) begin errors++;
      $display("FAIL imm_pos got %h zero=%b want 007f 0", w_data, rp_zero); end
  endtask

  task automatic test_add_wb();
    wr(1, 2'b01, 8'h0, 16'h7FFF);
    wr(2, 2'b10, 8'h01, 16'h0);
    alu_s = 3'b000;
    rd(1, 2);
    clock();
    checks++; if ({alu_q, carry_q, ovf_q} !== {16'h8000, 1'b0, 1'b1}) begin errors++;
      $display("FAIL add_ovf got %h c=%b v=%b want 8000 c=0 v=1", alu_q, carry_q, ovf_q); end
    wr(3, 2'b00, 8'h0, 16'h0);
    rd(3, 3);
    checks++; if (w_data !== 16'h8000) begin errors++; $display("FAIL wb_alu got %h want 8000", w_data); end
  endtask

  task automatic test_sub_shr();
    wr(1, 2'b10, 8'h01, 16'h0);
    wr(2, 2'b10, 8'h02, 16'h0);
    alu_s = 3'b001;
    rd(1, 2);
    clock();
    checks++; if ({alu_q, carry_q, ovf_q} !== {16'hFFFF, 1'b1, 1'b0}) begin errors++;
      $display("FAIL sub_borrow got %h c=%b v=%b want ffff c=1 v=0", alu_q, carry_q, ovf_q); end
    wr(6, 2'b01, 8'h0, 16'h8001);
    alu_s = 3'b111;
    rd(6, 6);
    clock();
    checks++; if ({alu_q, carry_q} !== {16'h4000, 1'b1}) begin errors++;
      $display("FAIL shr got %h c=%b want 4000 c=1", alu_q, carry_q); end
  endtask

  task automatic test_same_cycle();
    w_addr = 5; sel = 2'b01; r_data = 16'h1234; w_wr = 1;
    p_addr = 5; p_rd = 1;
    clock();
    idle();
    checks++; if (w_data !== 16'h0) begin errors++; $display("FAIL same_cycle_old got %h want 0000", w_data); end
    rd(5, 0);
    checks++; if (w_data !== 16'h1234) begin errors++; $display("FAIL same_cycle_new got %h want 1234", w_data); end
    clock();
    checks++; if (w_data !== 16'h1234) begin errors++; $display("FAIL latch_hold got %h want 1234", w_data); end
  endtask

  task automatic test_sel_err();
    wr(4, 2'b10, 8'h55, 16'h0);
    wr(4, 2'b11, 8'hAA, 16'hFFFF);
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_set got %b want 1", sel_err); end
    rd(4, 4);
    clock();
    checks++; if (w_data !== 16'h0055 || sel_err !== 1'b1) begin errors++;
      $display("FAIL sel_err_hold w_data=%h err=%b want 0055 1", w_data, sel_err); end
    w_addr = 4; sel = 2'b01; r_data = 16'hAAAA; w_wr = 1;
    #3 reset = 1; #1;
    checks++; if (sel_err !== 1'b0 || w_data !== 16'h0) begin errors++;
      $display("FAIL async_reset err=%b w_data=%h want 0 0000", sel_err, w_data); end
    @(posedge clk); #1;
    idle(); reset = 0;
    model_reset();
    rd(4, 4);
    checks++; if (w_data !== 16'h0 || rp_zero !== 1'b1) begin errors++;
      $display("FAIL reset_no_write got %h zero=%b want 0000 1", w_data, rp_zero); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_s  = 3'($urandom_range(0, 7));
      w_addr = 4'($urandom); p_addr = 4'($urandom); q_addr = 4'($urandom);
      w_wr   = 1'($urandom); p_rd = 1'($urandom); q_rd = 1'($urandom);
      sel    = $urandom_range(0, 15) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      imm    = 8'($urandom);
      r_data = $urandom_range(0, 3) == 0 ? 16'hFFFF * 16'($urandom_range(0, 1)) : 16'($urandom);
      clock();
      checks++;
      if ({alu_q, carry_q, ovf_q, w_data, rp_zero, sel_err} !==
          {16'(m_alu), m_c, m_v, 16'(m_rp), m_rp == 0, m_err}) begin
        errors++;
        $display("FAIL random[%0d] got alu=%h c=%b v=%b wd=%h z=%b e=%b want alu=%h c=%b v=%b wd=%h z=%b e=%b",
                 n, alu_q, carry_q, ovf_q, w_data, rp_zero, sel_err, 16'(m_alu), m_c, m_v, 16'(m_rp), m_rp == 0, m_err);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_imm();
    test_add_wb();
    test_sub_shr();
    test_same_cycle();
    test_sel_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
